// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use stalls, taken-branch
// flushes and multi-cycle MULT/DIV issue holds for the IF/ID, PC and ID/EX controls.
module hazard_ctrl #(
   parameter int unsigned MULDIV_LAT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rt,
   input  logic             ID_muldiv,
   input  logic             EX_memread,
   input  logic [4:0]       EX_rt,
   input  logic             EX_branch_taken,
   output logic             pc_write,
   output logic             ifid_stall,
   output logic             ifid_nop,
   output logic             idex_nop,
   output logic             muldiv_busy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned MD_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
   localparam logic [MD_W-1:0] MD_INIT = MD_W'(MULDIV_LAT - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      MD_ISSUE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [MD_W-1:0] md_cnt, md_cnt_nxt;
   logic            lu_hazard;

   // A load in EX writing a register the ID instruction reads; $zero never hazards
   assign lu_hazard = EX_memread && (EX_rt != 5'd0) &&
                      ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // Outputs are combinational so IFID and PC act on the same edge as the decision
   always_comb begin
      state_nxt   = RUN;
      md_cnt_nxt  = md_cnt;
      pc_write    = 1'b1;
      ifid_stall  = 1'b0;
      ifid_nop    = 1'b0;
      idex_nop    = 1'b0;
      muldiv_busy = 1'b0;
      case (state)
         RUN: begin
            if (EX_branch_taken) begin
               ifid_nop = 1'b1;
               idex_nop = 1'b1;
            end else if (lu_hazard) begin
               pc_write   = 1'b0;
               ifid_stall = 1'b1;
               idex_nop   = 1'b1;
            end else if (ID_muldiv) begin
               pc_write   = 1'b0;
               ifid_stall = 1'b1;
               idex_nop   = 1'b1;
               md_cnt_nxt = MD_INIT;
               state_nxt  = (MULDIV_LAT == 1) ? MD_ISSUE : MD_WAIT;
            end
         end
         MD_WAIT: begin
            pc_write    = 1'b0;
            ifid_stall  = 1'b1;
            idex_nop    = 1'b1;
            muldiv_busy = 1'b1;
            md_cnt_nxt  = md_cnt - 1'b1;
            state_nxt   = (md_cnt <= MD_W'(1)) ? MD_ISSUE : MD_WAIT;
         end
         MD_ISSUE: state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   // Saturating performance counters
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (ifid_stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (ifid_nop && (flush_count != {CNT_W{1'b1}}))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule
